imem_loader: RTL

Boot-time writer for the instruction memory. It accepts a byte stream from the serial receiver, packs the bytes big-endian into 32-bit instruction words, and issues one write per word into the instruction RAM at consecutive word-aligned byte addresses. While loading, it holds the CPU in reset, then releases it. It also reports capacity overflow with the same semantics as the instruction memory's `overflow` output.

---
 rtl/imem_pkg.sv | 14 +
 rtl/word_packer.sv | 34 +++
 rtl/imem_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

    localparam int ROM_SIZE_DEFAULT = 32;
    localparam int WORD_BYTES       = 4;

    typedef enum logic [1:0] {
        HDR_HI = 2'd0,
        HDR_LO = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream big-endian into 32-bit words; strobes combinationally on the 4th byte.
module word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_en,
    output logic [31:0] word,
    output logic        word_strobe
);

    logic [23:0] lanes;
    logic [1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes <= '0;
            cnt   <= '0;
        end else if (clear) begin
            lanes <= '0;
            cnt   <= '0;
        end else if (byte_en) begin
            lanes <= {lanes[15:0], byte_data};
            cnt   <= cnt + 2'd1;
        end
    end

    // The current byte completes the word in the same cycle it is accepted.
    assign word_strobe = byte_en && (cnt == 2'(WORD_BYTES - 1));
    assign word        = {lanes, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header-driven byte stream into instruction RAM writes, holding the CPU until done.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ROM_SIZE = ROM_SIZE_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        wr_en,
    output logic [30:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        overflow,
    output logic        done,
    output logic        cpu_hold
);

    state_t           state;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] word_index;
    logic [CNT_W-1:0] hdr_full;
    logic             accept;
    logic             word_strobe;
    logic [31:0]      word;

    assign in_ready = (state != DONE);
    assign cpu_hold = (state != DONE);
    assign accept   = in_valid && in_ready;
    assign hdr_full = {word_count[CNT_W-1:8], in_data};

    word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start && (state == DONE)),
        .byte_data   (in_data),
        .byte_en     (accept && (state == DATA)),
        .word        (word),
        .word_strobe (word_strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HDR_HI;
            word_count <= '0;
            word_index <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                HDR_HI: if (accept) begin
                    word_count <= CNT_W'({in_data, 8'h00});
                    state      <= HDR_LO;
                end
                HDR_LO: if (accept) begin
                    word_count <= hdr_full;
                    if (hdr_full == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (word_strobe) begin
                    // Words past capacity are still counted so the stream stays aligned.
                    if (32'(word_index) < ROM_SIZE) begin
                        wr_en   <= 1'b1;
                        wr_addr <= 31'({word_index, 2'b00});
                        wr_data <= word;
                    end else begin
                        overflow <= 1'b1;
                    end
                    word_index <= word_index + CNT_W'(1);
                    if (word_index == word_count - CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: if (start) begin
                    word_index <= '0;
                    overflow   <= 1'b0;
                    done       <= 1'b0;
                    state      <= HDR_HI;
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule
